// File: rtl/flu_wb_arbiter_if.sv
// Writeback arbiter bus: single-cycle source, multi-cycle handshake source,
// writeback port to the scoreboard, flush and issue-stall request.
interface flu_wb_arbiter_if #(
    parameter int unsigned XLEN          = 64,
    parameter int unsigned TRANS_ID_BITS = 3
);
    logic                     flush_i;
    logic                     sc_valid_i;
    logic [XLEN-1:0]          sc_result_i;
    logic [TRANS_ID_BITS-1:0] sc_trans_id_i;
    logic                     mc_valid_i;
    logic                     mc_ready_o;
    logic [XLEN-1:0]          mc_result_i;
    logic [TRANS_ID_BITS-1:0] mc_trans_id_i;
    logic                     wb_valid_o;
    logic [XLEN-1:0]          wb_result_o;
    logic [TRANS_ID_BITS-1:0] wb_trans_id_o;
    logic                     issue_stall_o;

    // Pipeline side: drives results, consumes writeback
    modport master (
        output flush_i, sc_valid_i, sc_result_i, sc_trans_id_i,
        output mc_valid_i, mc_result_i, mc_trans_id_i,
        input  mc_ready_o, wb_valid_o, wb_result_o, wb_trans_id_o, issue_stall_o
    );

    // Arbiter side
    modport slave (
        input  flush_i, sc_valid_i, sc_result_i, sc_trans_id_i,
        input  mc_valid_i, mc_result_i, mc_trans_id_i,
        output mc_ready_o, wb_valid_o, wb_result_o, wb_trans_id_o, issue_stall_o
    );
endinterface

// File: rtl/flu_wb_arbiter.sv
// Fixed-latency-unit writeback arbiter. Single-cycle results always win;
// multi-cycle results that lose are queued in order and drained when the
// single-cycle path is idle. A starvation guard requests an issue stall when
// the queue head has been blocked for MAX_WAIT cycles.
module flu_wb_arbiter #(
    parameter int unsigned XLEN          = 64,
    parameter int unsigned TRANS_ID_BITS = 3,
    parameter int unsigned DEPTH         = 2,
    parameter int unsigned MAX_WAIT      = 4
) (
    input logic             clk_i,
    input logic             rst_ni,
    flu_wb_arbiter_if.slave bus
);
    localparam int unsigned PtrW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW  = $clog2(DEPTH + 1);
    localparam int unsigned WaitW = $clog2(MAX_WAIT + 1);

    logic [XLEN-1:0]          res_q [DEPTH];
    logic [TRANS_ID_BITS-1:0] id_q  [DEPTH];
    logic [PtrW-1:0]          wr_q, rd_q;
    logic [CntW-1:0]          count_q, count_d;
    logic [WaitW-1:0]         wait_q, wait_d;
    logic                     stall_q, stall_d;

    logic                     kill, empty, full, accept, enq, deq;
    logic                     wb_valid;
    logic [XLEN-1:0]          wb_result;
    logic [TRANS_ID_BITS-1:0] wb_id;

    // Output priority mux and enqueue/dequeue decisions
    always_comb begin
        kill      = bus.flush_i | ~rst_ni;
        empty     = (count_q == '0);
        full      = (count_q == CntW'(DEPTH));
        accept    = bus.mc_valid_i & ~full;
        wb_valid  = 1'b0;
        wb_result = '0;
        wb_id     = '0;
        enq       = 1'b0;
        deq       = 1'b0;
        if (kill) begin
            // Anything accepted now is dropped; only the sc path may write back
            if (bus.sc_valid_i) begin
                wb_valid  = 1'b1;
                wb_result = bus.sc_result_i;
                wb_id     = bus.sc_trans_id_i;
            end
        end else if (bus.sc_valid_i) begin
            wb_valid  = 1'b1;
            wb_result = bus.sc_result_i;
            wb_id     = bus.sc_trans_id_i;
            enq       = accept;
        end else if (!empty) begin
            wb_valid  = 1'b1;
            wb_result = res_q[rd_q];
            wb_id     = id_q[rd_q];
            deq       = 1'b1;
            enq       = accept;
        end else if (bus.mc_valid_i) begin
            // Bypass only when empty keeps acceptance order intact
            wb_valid  = 1'b1;
            wb_result = bus.mc_result_i;
            wb_id     = bus.mc_trans_id_i;
        end
    end

    // Next-state for occupancy and the starvation guard
    always_comb begin
        count_d = count_q + CntW'(enq) - CntW'(deq);
        if (empty || deq) begin
            wait_d = '0;
        end else if (bus.sc_valid_i && (wait_q != WaitW'(MAX_WAIT))) begin
            wait_d = wait_q + WaitW'(1);
        end else begin
            wait_d = wait_q;
        end
        if (deq) begin
            stall_d = 1'b0;
        end else if (wait_d == WaitW'(MAX_WAIT)) begin
            stall_d = 1'b1;
        end else begin
            stall_d = stall_q;
        end
    end

    // Control state with synchronous reset; flush empties the queue
    always_ff @(posedge clk_i) begin
        if (!rst_ni || bus.flush_i) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
            wait_q  <= '0;
            stall_q <= 1'b0;
        end else begin
            if (enq) wr_q <= wr_q + PtrW'(1);
            if (deq) rd_q <= rd_q + PtrW'(1);
            count_q <= count_d;
            wait_q  <= wait_d;
            stall_q <= stall_d;
        end
    end

    // Queue storage, not reset
    always_ff @(posedge clk_i) begin
        if (enq) begin
            res_q[wr_q] <= bus.mc_result_i;
            id_q[wr_q]  <= bus.mc_trans_id_i;
        end
    end

    assign bus.mc_ready_o    = ~full;
    assign bus.wb_valid_o    = wb_valid;
    assign bus.wb_result_o   = wb_result;
    assign bus.wb_trans_id_o = wb_id;
    assign bus.issue_stall_o = stall_q;

    // The issue stage must honour the stall request
    sc_while_stall: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(bus.sc_valid_i && stall_q));
endmodule

// File: tb/tb_flu_wb_arbiter.sv
// Self-checking bench for flu_wb_arbiter: directed scenarios plus a random
// run against a queue-based reference model.
module tb_flu_wb_arbiter;
    localparam int unsigned XLEN     = 64;
    localparam int unsigned TID      = 3;
    localparam int unsigned DEPTH    = 2;
    localparam int unsigned MAX_WAIT = 4;

    typedef struct packed {
        logic [XLEN-1:0] r;
        logic [TID-1:0]  id;
    } ent_t;

    logic clk;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;

    flu_wb_arbiter_if #(.XLEN(XLEN), .TRANS_ID_BITS(TID)) bus ();

    flu_wb_arbiter #(
        .XLEN(XLEN), .TRANS_ID_BITS(TID), .DEPTH(DEPTH), .MAX_WAIT(MAX_WAIT)
    ) dut (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle();
        bus.flush_i = 1'b0; bus.sc_valid_i = 1'b0; bus.sc_result_i = '0;
        bus.sc_trans_id_i = '0; bus.mc_valid_i = 1'b0; bus.mc_result_i = '0;
        bus.mc_trans_id_i = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic drive_sc(input logic v, input logic [XLEN-1:0] r, input logic [TID-1:0] id);
        bus.sc_valid_i = v; bus.sc_result_i = r; bus.sc_trans_id_i = id;
    endtask

    task automatic drive_mc(input logic v, input logic [XLEN-1:0] r, input logic [TID-1:0] id);
        bus.mc_valid_i = v; bus.mc_result_i = r; bus.mc_trans_id_i = id;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; idle(); tick(); rst_n = 1'b1;
        settle();
        total++; if (bus.mc_ready_o !== 1'b1) begin bad++;
            $display("FAIL reset_ready got=%b exp=1", bus.mc_ready_o); end
        total++; if (bus.wb_valid_o !== 1'b0) begin bad++;
            $display("FAIL reset_valid got=%b exp=0", bus.wb_valid_o); end
        total++; if (bus.wb_result_o !== '0 || bus.wb_trans_id_o !== '0) begin bad++;
            $display("FAIL reset_data got=%h/%0d exp=0/0", bus.wb_result_o, bus.wb_trans_id_o); end
        total++; if (bus.issue_stall_o !== 1'b0) begin bad++;
            $display("FAIL reset_stall got=%b exp=0", bus.issue_stall_o); end
        tick();
        drive_sc(1'b1, 64'h77, 3'd6);
        settle();
        total++; if (bus.wb_valid_o !== 1'b1 || bus.wb_result_o !== 64'h77
                     || bus.wb_trans_id_o !== 3'd6) begin bad++;
            $display("FAIL reset_sc got=%b/%h/%0d exp=1/77/6", bus.wb_valid_o,
                     bus.wb_result_o, bus.wb_trans_id_o); end
        tick(); idle();
    endtask

    task automatic test_bypass();
        drive_mc(1'b1, 64'hA5, 3'd2);
        settle();
        total++; if (bus.wb_valid_o !== 1'b1 || bus.wb_result_o !== 64'hA5
                     || bus.wb_trans_id_o !== 3'd2) begin bad++;
            $display("FAIL bypass got=%b/%h/%0d exp=1/a5/2", bus.wb_valid_o,
                     bus.wb_result_o, bus.wb_trans_id_o); end
        tick(); idle();
        settle();
        total++; if (bus.wb_valid_o !== 1'b0 || bus.mc_ready_o !== 1'b1) begin bad++;
            $display("FAIL bypass_noenq got valid=%b ready=%b exp=0/1", bus.wb_valid_o,
                     bus.mc_ready_o); end
        tick();
    endtask

    task automatic test_collision();
        drive_sc(1'b1, 64'h11, 3'd1);
        drive_mc(1'b1, 64'h22, 3'd3);
        settle();
        total++; if (bus.wb_valid_o !== 1'b1 || bus.wb_result_o !== 64'h11
                     || bus.wb_trans_id_o !== 3'd1) begin bad++;
            $display("FAIL coll_sc got=%b/%h/%0d exp=1/11/1", bus.wb_valid_o,
                     bus.wb_result_o, bus.wb_trans_id_o); end
        tick(); idle();
        settle();
        total++; if (bus.wb_valid_o !== 1'b1 || bus.wb_result_o !== 64'h22
                     || bus.wb_trans_id_o !== 3'd3) begin bad++;
            $display("FAIL coll_drain got=%b/%h/%0d exp=1/22/3", bus.wb_valid_o,
                     bus.wb_result_o, bus.wb_trans_id_o); end
        tick();
        settle();
        total++; if (bus.wb_valid_o !== 1'b0) begin bad++;
            $display("FAIL coll_empty got=%b exp=0", bus.wb_valid_o); end
        tick();
    endtask

    task automatic test_full();
        drive_sc(1'b1, 64'h100, 3'd0); drive_mc(1'b1, 64'h44, 3'd4);
        settle();
        total++; if (bus.mc_ready_o !== 1'b1) begin bad++;
            $display("FAIL full_rdy0 got=%b exp=1", bus.mc_ready_o); end
        tick();
        drive_sc(1'b1, 64'h101, 3'd0); drive_mc(1'b1, 64'h55, 3'd5);
        settle();
        total++; if (bus.mc_ready_o !== 1'b1) begin bad++;
            $display("FAIL full_rdy1 got=%b exp=1", bus.mc_ready_o); end
        tick();
        drive_sc(1'b1, 64'h102, 3'd0); drive_mc(1'b0, '0, '0);
        settle();
        total++; if (bus.mc_ready_o !== 1'b0) begin bad++;
            $display("FAIL full_rdy2 got=%b exp=0", bus.mc_ready_o); end
        tick(); idle();
        settle();
        total++; if (bus.wb_valid_o !== 1'b1 || bus.wb_trans_id_o !== 3'd4
                     || bus.wb_result_o !== 64'h44 || bus.mc_ready_o !== 1'b0) begin bad++;
            $display("FAIL full_drain0 got=%b/%h/%0d rdy=%b exp=1/44/4 rdy=0", bus.wb_valid_o,
                     bus.wb_result_o, bus.wb_trans_id_o, bus.mc_ready_o); end
        tick();
        settle();
        total++; if (bus.wb_valid_o !== 1'b1 || bus.wb_trans_id_o !== 3'd5
                     || bus.wb_result_o !== 64'h55 || bus.mc_ready_o !== 1'b1) begin bad++;
            $display("FAIL full_drain1 got=%b/%h/%0d rdy=%b exp=1/55/5 rdy=1", bus.wb_valid_o,
                     bus.wb_result_o, bus.wb_trans_id_o, bus.mc_ready_o); end
        tick();
        settle();
        total++; if (bus.wb_valid_o !== 1'b0) begin bad++;
            $display("FAIL full_empty got=%b exp=0", bus.wb_valid_o); end
        tick();
    endtask

    task automatic test_starvation();
        drive_sc(1'b1, 64'h200, 3'd0); drive_mc(1'b1, 64'h77, 3'd7);
        tick();
        drive_mc(1'b0, '0, '0);
        for (int c = 1; c <= 4; c++) begin
            drive_sc(1'b1, 64'(c), 3'd1);
            settle();
            total++; if (bus.issue_stall_o !== 1'b0) begin bad++;
                $display("FAIL starve_early c=%0d got=%b exp=0", c, bus.issue_stall_o); end
            tick();
        end
        idle();
        settle();
        total++; if (bus.issue_stall_o !== 1'b1) begin bad++;
            $display("FAIL starve_set got=%b exp=1", bus.issue_stall_o); end
        total++; if (bus.wb_valid_o !== 1'b1 || bus.wb_trans_id_o !== 3'd7
                     || bus.wb_result_o !== 64'h77) begin bad++;
            $display("FAIL starve_drain got=%b/%h/%0d exp=1/77/7", bus.wb_valid_o,
                     bus.wb_result_o, bus.wb_trans_id_o); end
        tick();
        settle();
        total++; if (bus.issue_stall_o !== 1'b0 || bus.wb_valid_o !== 1'b0) begin bad++;
            $display("FAIL starve_clear got stall=%b valid=%b exp=0/0", bus.issue_stall_o,
                     bus.wb_valid_o); end
        tick();
    endtask

    task automatic test_flush();
        drive_sc(1'b1, 64'h300, 3'd0); drive_mc(1'b1, 64'hA1, 3'd1);
        tick();
        drive_sc(1'b1, 64'h301, 3'd0); drive_mc(1'b1, 64'hA2, 3'd2);
        tick();
        drive_mc(1'b0, '0, '0);
        bus.flush_i = 1'b1; drive_sc(1'b1, 64'h33, 3'd3);
        settle();
        total++; if (bus.wb_valid_o !== 1'b1 || bus.wb_result_o !== 64'h33
                     || bus.wb_trans_id_o !== 3'd3) begin bad++;
            $display("FAIL flush_sc got=%b/%h/%0d exp=1/33/3", bus.wb_valid_o,
                     bus.wb_result_o, bus.wb_trans_id_o); end
        total++; if (bus.mc_ready_o !== 1'b0) begin bad++;
            $display("FAIL flush_rdy_hold got=%b exp=0", bus.mc_ready_o); end
        tick(); idle();
        settle();
        total++; if (bus.mc_ready_o !== 1'b1 || bus.issue_stall_o !== 1'b0
                     || bus.wb_valid_o !== 1'b0) begin bad++;
            $display("FAIL flush_after got rdy=%b stall=%b valid=%b exp=1/0/0",
                     bus.mc_ready_o, bus.issue_stall_o, bus.wb_valid_o); end
        tick();
        settle();
        total++; if (bus.wb_valid_o !== 1'b0) begin bad++;
            $display("FAIL flush_stale got=%b exp=0", bus.wb_valid_o); end
        tick();
    endtask

    task automatic test_reset_mid();
        drive_sc(1'b1, 64'h400, 3'd0); drive_mc(1'b1, 64'hB1, 3'd1);
        tick();
        drive_mc(1'b1, 64'hB2, 3'd2);
        tick();
        drive_mc(1'b0, '0, '0);
        tick(); tick(); tick();
        idle(); rst_n = 1'b0;
        settle();
        total++; if (bus.issue_stall_o !== 1'b1 || bus.mc_ready_o !== 1'b0) begin bad++;
            $display("FAIL rstmid_pre got stall=%b rdy=%b exp=1/0", bus.issue_stall_o,
                     bus.mc_ready_o); end
        total++; if (bus.wb_valid_o !== 1'b0) begin bad++;
            $display("FAIL rstmid_kill got=%b exp=0", bus.wb_valid_o); end
        tick(); rst_n = 1'b1;
        drive_sc(1'b1, 64'h99, 3'd4);
        settle();
        total++; if (bus.mc_ready_o !== 1'b1 || bus.issue_stall_o !== 1'b0) begin bad++;
            $display("FAIL rstmid_post got rdy=%b stall=%b exp=1/0", bus.mc_ready_o,
                     bus.issue_stall_o); end
        total++; if (bus.wb_valid_o !== 1'b1 || bus.wb_result_o !== 64'h99
                     || bus.wb_trans_id_o !== 3'd4) begin bad++;
            $display("FAIL rstmid_sc got=%b/%h/%0d exp=1/99/4", bus.wb_valid_o,
                     bus.wb_result_o, bus.wb_trans_id_o); end
        tick(); idle();
        settle();
        total++; if (bus.wb_valid_o !== 1'b0) begin bad++;
            $display("FAIL rstmid_empty got=%b exp=0", bus.wb_valid_o); end
        tick();
    endtask

    // Random traffic against a queue model of the arbitration rules
    task automatic test_random();
        ent_t            mq[$];
        ent_t            e;
        int              m_wait;
        bit              m_stall, pend, sc, fl, acc, deq, ev, erdy;
        int              n0;
        logic [XLEN-1:0] pres, er;
        logic [TID-1:0]  pid, eid;
        rst_n = 1'b0; idle(); tick(); rst_n = 1'b1;
        m_wait = 0; m_stall = 1'b0; pend = 1'b0; pres = '0; pid = '0;
        for (int c = 0; c < 600; c++) begin
            fl = ($urandom_range(0, 15) == 0);
            sc = !m_stall && ($urandom_range(0, 4) < 3);
            if (!pend && ($urandom_range(0, 1) == 1)) begin
                pend = 1'b1;
                pres = {$urandom, $urandom};
                pid  = TID'($urandom_range(0, 7));
            end
            bus.flush_i = fl;
            drive_sc(sc, {$urandom, $urandom}, TID'($urandom_range(0, 7)));
            drive_mc(pend, pend ? pres : '0, pend ? pid : '0);
            n0 = mq.size();
            erdy = (n0 < DEPTH);
            ev = 1'b0; er = '0; eid = '0; deq = 1'b0;
            if (sc) begin
                ev = 1'b1; er = bus.sc_result_i; eid = bus.sc_trans_id_i;
            end else if (!fl && n0 > 0) begin
                ev = 1'b1; er = mq[0].r; eid = mq[0].id; deq = 1'b1;
            end else if (!fl && pend) begin
                ev = 1'b1; er = pres; eid = pid;
            end
            settle();
            total++; if (bus.wb_valid_o !== ev) begin bad++;
                $display("FAIL rnd_valid c=%0d got=%b exp=%b", c, bus.wb_valid_o, ev); end
            total++; if (bus.wb_result_o !== er || bus.wb_trans_id_o !== eid) begin bad++;
                $display("FAIL rnd_data c=%0d got=%h/%0d exp=%h/%0d", c, bus.wb_result_o,
                         bus.wb_trans_id_o, er, eid); end
            total++; if (bus.mc_ready_o !== erdy) begin bad++;
                $display("FAIL rnd_ready c=%0d got=%b exp=%b", c, bus.mc_ready_o, erdy); end
            total++; if (bus.issue_stall_o !== m_stall) begin bad++;
                $display("FAIL rnd_stall c=%0d got=%b exp=%b", c, bus.issue_stall_o, m_stall);
            end
            acc = pend && erdy;
            if (fl) begin
                mq.delete(); m_wait = 0; m_stall = 1'b0;
            end else begin
                if (deq) void'(mq.pop_front());
                if (acc && (sc || n0 > 0)) begin
                    e.r = pres; e.id = pid; mq.push_back(e);
                end
                if (n0 == 0 || deq) m_wait = 0;
                else if (sc && m_wait < MAX_WAIT) m_wait++;
                if (deq) m_stall = 1'b0;
                else if (m_wait == MAX_WAIT) m_stall = 1'b1;
            end
            if (acc) pend = 1'b0;
            tick();
        end
        idle();
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        test_reset();
        test_bypass();
        test_collision();
        test_full();
        test_starvation();
        test_flush();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
